// File: rtl/joint_pwm_pkg.sv
// Shared definitions for the joint PWM controller: FSM encoding, default
// parameter values and the duty magnitude helper.
package joint_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int DEF_NUM_JOINTS = 4;
    localparam int DEF_PWM_PERIOD = 100000;
    localparam int DEF_WD_PERIODS = 16;

    // 33-bit result so that -2^31 has a representable magnitude.
    function automatic logic [32:0] duty_abs(input logic signed [31:0] d);
        return d[31] ? (33'd0 - {1'b1, d}) : {1'b0, d};
    endfunction

endpackage

// File: rtl/joint_pwm_chan.sv
// One joint channel: pending/active duty registers, registered PWM compare
// and boundary-aligned direction output.
module joint_pwm_chan #(
    parameter int CW = 17,
    parameter int MW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [MW-1:0] wr_mag,
    input  logic          wr_dir,
    input  logic          load,
    input  logic [CW-1:0] cnt,
    output logic          pwm,
    output logic          dir
);

    logic [MW-1:0] pend_mag;
    logic [MW-1:0] act_mag;
    logic          pend_dir;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pend_mag <= '0;
            pend_dir <= 1'b0;
            act_mag  <= '0;
            dir      <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            if (wr_en) begin
                pend_mag <= wr_mag;
                pend_dir <= wr_dir;
            end
            // Active takes the pre-write pending value, so a command in the
            // strobe cycle waits for the following boundary.
            if (load) begin
                act_mag <= pend_mag;
                dir     <= pend_dir;
            end
            pwm <= MW'(cnt) < act_mag;
        end
    end

endmodule

// File: rtl/joint_pwm_ctrl.sv
// Multi-joint PWM/DIR controller with period counter, run/fault FSM,
// command decode and a period-based command watchdog.
module joint_pwm_ctrl
    import joint_pwm_pkg::*;
#(
    parameter int NUM_JOINTS = DEF_NUM_JOINTS,
    parameter int PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int WD_PERIODS = DEF_WD_PERIODS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [((NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1)-1:0] cmd_joint,
    input  logic signed [31:0]    cmd_duty,
    output logic [NUM_JOINTS-1:0] PWM,
    output logic [NUM_JOINTS-1:0] DIR,
    output logic                  period_strobe,
    output logic                  wd_fault
);

    localparam int JW  = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
    localparam int CW  = $clog2(PWM_PERIOD);
    localparam int MW  = $clog2(PWM_PERIOD + 1);
    localparam int WDW = $clog2(WD_PERIODS + 1);

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [WDW-1:0]          wd;
    logic                    run, strobe, accept, expire;
    logic [32:0]             mag_full;
    logic [MW-1:0]           duty_mag;
    logic                    duty_dir;
    logic [NUM_JOINTS-1:0]   wr_en, pwm_q, dir_q;

    assign run    = state == ST_RUN;
    assign strobe = run && (cnt == CW'(PWM_PERIOD - 1));
    assign accept = cmd_valid && cmd_ready;
    assign expire = strobe && !accept && (wd == WDW'(WD_PERIODS - 1));

    // Outputs are forced low while rst is held, ahead of the reset edge.
    assign cmd_ready     = !rst && (state != ST_FAULT);
    assign period_strobe = !rst && strobe;
    assign wd_fault      = !rst && (state == ST_FAULT);
    assign PWM           = (run && !rst) ? pwm_q : '0;
    assign DIR           = (run && !rst) ? dir_q : '0;

    always_comb begin
        mag_full = duty_abs(cmd_duty);
        duty_mag = (mag_full > 33'(PWM_PERIOD)) ? MW'(PWM_PERIOD) : MW'(mag_full);
        duty_dir = !cmd_duty[31] && (cmd_duty != 32'sd0);
    end

    for (genvar j = 0; j < NUM_JOINTS; j++) begin : g_chan
        // Out-of-range joint indices match no channel and are dropped.
        assign wr_en[j] = accept && run && (cmd_joint == JW'(j));

        joint_pwm_chan #(.CW(CW), .MW(MW)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .clr    (!run),
            .wr_en  (wr_en[j]),
            .wr_mag (duty_mag),
            .wr_dir (duty_dir),
            .load   (strobe),
            .cnt    (cnt),
            .pwm    (pwm_q[j]),
            .dir    (dir_q[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            wd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    wd  <= '0;
                    if (enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable || expire) begin
                        state <= enable ? ST_FAULT : ST_IDLE;
                        cnt   <= '0;
                        wd    <= '0;
                    end else begin
                        cnt <= strobe ? '0 : cnt + 1'b1;
                        if (accept)      wd <= '0;
                        else if (strobe) wd <= wd + 1'b1;
                    end
                end
                ST_FAULT: begin
                    cnt <= '0;
                    wd  <= '0;
                    if (!enable) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    wd    <= '0;
                end
            endcase
        end
    end

endmodule
